// File: rtl/ifft_pkg.sv
// Shared types and helpers for the IFFT output reorder block.
// Holds the sample width, transform size, read FSM encoding and bit reversal.
package ifft_pkg;

   localparam int DATA_WIDTH = 18;
   localparam int LOG2N      = 6;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rd_state_t;

   function automatic logic [15:0] bitrev(
      input logic [15:0] addr,
      input int          log2n
   );
      logic [15:0] res;
      res = '0;
      for (int b = 0; b < 16; b++) begin
         if (b < log2n) res[b] = addr[log2n-1-b];
      end
      return res;
   endfunction

endpackage

// File: rtl/ifft_reorder_bank.sv
// Complex register file: one write port, one read port, registered read data.
// The read register resets so the downstream outputs are zero after reset.
module ifft_reorder_bank
   import ifft_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int NFFT       = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [$clog2(NFFT)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]   wdata_r,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    re,
   input  logic [$clog2(NFFT)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]   rdata_r,
   output logic [DATA_WIDTH-1:0]   rdata_i
);

   logic [2*DATA_WIDTH-1:0] mem [NFFT];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= {wdata_r, wdata_i};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_r <= '0;
         rdata_i <= '0;
      end else if (re) begin
         {rdata_r, rdata_i} <= mem[raddr];
      end
   end

endmodule

// File: rtl/ifft_output_reorder.sv
// Ping-pong reorder of the bit-reversed stage-6 stream into natural order,
// with optional rounded 1/NFFT normalisation and framing flags.
module ifft_output_reorder
   import ifft_pkg::*;
#(
   parameter int INTEGER_SIZE = 6,
   parameter int FRACT_SIZE   = 12,
   parameter int NFFT         = 64,
   parameter int SCALE_EN     = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start_conv,
   input  logic                                  in_valid,
   input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] serial_in_r,
   input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] serial_in_i,
   output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] out_r,
   output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] out_i,
   output logic                                  out_valid,
   output logic                                  out_first,
   output logic                                  end_conv
);

   localparam int DW = INTEGER_SIZE + FRACT_SIZE;
   localparam int AW = $clog2(NFFT);
   localparam logic [AW-1:0] LAST = AW'(NFFT - 1);

   rd_state_t       state, state_nx;
   logic [AW-1:0]   wcnt, rcnt, wr_addr;
   logic            wbank, rbank, armed;
   logic [1:0]      full, full_set, full_clr;
   logic            wr_en, wr_done, rd_en, rd_last;
   logic [DW-1:0]   rd_r, rd_i;

   // Nothing is written until the first start_conv after reset.
   assign wr_en    = in_valid & (start_conv | armed);
   assign wr_addr  = start_conv ? '0 : AW'(bitrev(16'(wcnt), AW));
   assign wr_done  = wr_en & ~start_conv & (wcnt == LAST);
   assign full_set = wr_done ? (2'b01 << wbank) : 2'b00;

   assign rd_en    = (state == READ);
   assign rd_last  = rd_en & (rcnt == LAST);
   assign full_clr = rd_last ? (2'b01 << rbank) : 2'b00;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt  <= '0;
         wbank <= 1'b0;
         armed <= 1'b0;
      end else if (wr_en) begin
         armed <= 1'b1;
         if (start_conv) begin
            wcnt <= AW'(1);
         end else if (wr_done) begin
            wcnt  <= '0;
            wbank <= ~wbank;
         end else begin
            wcnt <= wcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) full <= '0;
      else      full <= (full | full_set) & ~full_clr;
   end

   // Stay in READ across the bank swap when the other bank is ready.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (full[rbank]) state_nx = READ;
         READ: if (rd_last && !(full[~rbank] || full_set[~rbank]))
                  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rcnt      <= '0;
         rbank     <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         end_conv  <= 1'b0;
      end else begin
         state     <= state_nx;
         out_valid <= rd_en;
         out_first <= rd_en & (rcnt == '0);
         end_conv  <= rd_last;
         if (rd_en) begin
            rcnt <= rcnt + 1'b1;
            if (rd_last) rbank <= ~rbank;
         end
      end
   end

   ifft_reorder_bank #(
      .DATA_WIDTH(DW),
      .NFFT      (2*NFFT)
   ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (wr_en),
      .waddr  ({wbank, wr_addr}),
      .wdata_r(serial_in_r),
      .wdata_i(serial_in_i),
      .re     (rd_en),
      .raddr  ({rbank, rcnt}),
      .rdata_r(rd_r),
      .rdata_i(rd_i)
   );

   generate
      if (SCALE_EN != 0) begin : g_scale
         localparam logic signed [DW:0] RND = (DW+1)'(2**(AW-1));
         logic signed [DW:0] sum_r, sum_i;
         assign sum_r = $signed({rd_r[DW-1], rd_r}) + RND;
         assign sum_i = $signed({rd_i[DW-1], rd_i}) + RND;
         assign out_r = DW'(sum_r >>> AW);
         assign out_i = DW'(sum_i >>> AW);
      end else begin : g_pass
         assign out_r = rd_r;
         assign out_i = rd_i;
      end
   endgenerate

endmodule

// File: tb/tb_ifft_output_reorder.sv
// Scoreboard bench for ifft_output_reorder: pass-through and scaled
// instances share one stimulus stream and are checked against one queue.
module tb_ifft_output_reorder;

   localparam int DW = 18;

   typedef struct {
      logic signed [DW-1:0] r, i, sr, si;
      logic                 first, last;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start_conv = 1'b0;
   logic in_valid = 1'b0;
   logic signed [DW-1:0] serial_in_r = '0;
   logic signed [DW-1:0] serial_in_i = '0;
   logic signed [DW-1:0] out_r0, out_i0, out_r1, out_i1;
   logic out_valid0, out_first0, end_conv0;
   logic out_valid1, out_first1, end_conv1;

   int n_cmp = 0;
   int n_bad = 0;
   int run = 0;
   int last_run = 0;
   int total_valid = 0;
   ent_t sb[$];

   int fr_r[64], fr_i[64], fr_sr[64], fr_si[64];

   always #5 clk = ~clk;

   ifft_output_reorder #(
      .INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(64), .SCALE_EN(0)
   ) dut0 (
      .clk(clk), .rst(rst), .start_conv(start_conv), .in_valid(in_valid),
      .serial_in_r(serial_in_r), .serial_in_i(serial_in_i),
      .out_r(out_r0), .out_i(out_i0), .out_valid(out_valid0),
      .out_first(out_first0), .end_conv(end_conv0)
   );

   ifft_output_reorder #(
      .INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(64), .SCALE_EN(1)
   ) dut1 (
      .clk(clk), .rst(rst), .start_conv(start_conv), .in_valid(in_valid),
      .serial_in_r(serial_in_r), .serial_in_i(serial_in_i),
      .out_r(out_r1), .out_i(out_i1), .out_valid(out_valid1),
      .out_first(out_first1), .end_conv(end_conv1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int br6(input int j);
      int r;
      r = 0;
      for (int b = 0; b < 6; b++) if (j & (1 << b)) r |= 1 << (5 - b);
      return r;
   endfunction

   function automatic int scl(input int x);
      return (x + 32) >>> 6;
   endfunction

   task automatic set_frame(input int kind);
      for (int k = 0; k < 64; k++) begin
         case (kind)
            0: begin fr_r[k] = 64 * k;          fr_i[k] = -64 * k;      end
            1: begin fr_r[k] = 100 * k - 3000;  fr_i[k] = 5 * k + 7;    end
            2: begin fr_r[k] = 37 * k;          fr_i[k] = -(k * k);     end
            3: begin fr_r[k] = k;               fr_i[k] = 2 * k;        end
            4: begin fr_r[k] = -50 * k;         fr_i[k] = 1000 - k;     end
            default: begin fr_r[k] = 3 * k + 1; fr_i[k] = -7 * k - 11; end
         endcase
         fr_sr[k] = scl(fr_r[k]);
         fr_si[k] = scl(fr_i[k]);
      end
   endtask

   task automatic set_const(input int raw, input int sexp);
      for (int k = 0; k < 64; k++) begin
         fr_r[k] = raw;  fr_i[k] = raw;
         fr_sr[k] = sexp; fr_si[k] = sexp;
      end
   endtask

   task automatic drv(input bit s, input int dr, input int di, input bit gap);
      start_conv  = s;
      in_valid    = 1'b1;
      serial_in_r = DW'(dr);
      serial_in_i = DW'(di);
      @(posedge clk); #1;
      in_valid   = 1'b0;
      start_conv = 1'b0;
      if (gap) begin @(posedge clk); #1; end
   endtask

   task automatic drive_frame(input bit gap, input int pre);
      ent_t e;
      for (int j = 0; j < pre; j++)
         drv(j == 0, int'($urandom_range(4000)), int'($urandom_range(4000)), gap);
      for (int j = 0; j < 64; j++)
         drv(j == 0, fr_r[br6(j)], fr_i[br6(j)], gap);
      for (int k = 0; k < 64; k++) begin
         e.r = DW'(fr_r[k]);   e.i = DW'(fr_i[k]);
         e.sr = DW'(fr_sr[k]); e.si = DW'(fr_si[k]);
         e.first = (k == 0);   e.last = (k == 63);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid0) done = 1'b1;
      end
      if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_first();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (out_valid0 && out_first0) seen = 1'b1;
      end
      if (!seen) chk("first_timeout", 32'd1, 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid0"}, out_valid0, 0); chk({tag, "_valid1"}, out_valid1, 0);
      chk({tag, "_first0"}, out_first0, 0); chk({tag, "_first1"}, out_first1, 0);
      chk({tag, "_end0"}, end_conv0, 0);    chk({tag, "_end1"}, end_conv1, 0);
      chk({tag, "_r0"}, out_r0, 0);         chk({tag, "_i0"}, out_i0, 0);
      chk({tag, "_r1"}, out_r1, 0);         chk({tag, "_i1"}, out_i1, 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (out_valid0 || out_valid1) begin
            run++;
            total_valid++;
            if (sb.size() == 0) begin
               chk("spurious_valid", 32'd1, 32'd0);
            end else begin
               ent_t e;
               e = sb.pop_front();
               chk("valid0", out_valid0, 1);  chk("valid1", out_valid1, 1);
               chk("r_pass", out_r0, e.r);    chk("i_pass", out_i0, e.i);
               chk("r_scaled", out_r1, e.sr); chk("i_scaled", out_i1, e.si);
               chk("first0", out_first0, e.first);
               chk("first1", out_first1, e.first);
               chk("end0", end_conv0, e.last);
               chk("end1", end_conv1, e.last);
            end
         end else if (run != 0) begin
            last_run = run;
            run = 0;
         end
      end
   end

   int raws[5] = '{64, 95, 96, -96, -97};
   int sexp[5] = '{1, 1, 2, -1, -2};

   initial begin
      // Reset held with input activity
      for (int c = 0; c < 6; c++) begin
         in_valid = c[0];
         start_conv = (c == 2);
         serial_in_r = DW'(c * 99);
         @(negedge clk);
         chk_zero("rst_hold");
      end
      @(posedge clk); #1;
      in_valid = 1'b0; start_conv = 1'b0;
      rst = 1'b1;

      // Samples before any start_conv must be ignored
      for (int c = 0; c < 70; c++) drv(1'b0, c * 3, -c, 1'b0);
      repeat (80) @(negedge clk);
      chk("no_out_before_start", total_valid, 0);

      // Single frame, latency check
      set_frame(0);
      drive_frame(1'b0, 0);
      @(negedge clk); chk("lat_pre1", out_valid0, 0);
      @(negedge clk); chk("lat_pre2", out_valid0, 0);
      @(negedge clk); chk("lat_valid", out_valid0, 1);
      chk("lat_first", out_first0, 1);
      drain("single");
      chk("single_run", last_run, 64);

      // Scaling rounding corners
      for (int t = 0; t < 5; t++) begin
         set_const(raws[t], sexp[t]);
         drive_frame(1'b0, 0);
         drain("scale");
      end

      // Back-to-back frames, no bubble
      set_frame(3);
      drive_frame(1'b0, 0);
      set_frame(4);
      drive_frame(1'b0, 0);
      drain("b2b");
      chk("b2b_run", last_run, 128);

      // Gapped input
      set_frame(1);
      drive_frame(1'b1, 0);
      drain("gap");
      chk("gap_run", last_run, 64);

      // Restart at sample 20
      set_frame(2);
      drive_frame(1'b0, 20);
      drain("restart");
      chk("restart_run", last_run, 64);

      // Reset in the middle of a read
      set_frame(0);
      drive_frame(1'b0, 0);
      wait_first();
      repeat (30) @(negedge clk);
      #1 rst = 1'b0;
      #1 chk_zero("rst_mid");
      sb.delete();
      run = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      set_frame(5);
      drive_frame(1'b0, 0);
      drain("post_rst");
      chk("post_rst_run", last_run, 64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
